// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus layout, CP0 register
// numbers, exception codes and the exception entry vector.
package wb_stage_pkg;

  localparam int          MS_TO_WS_BUS_WD = 125;
  localparam logic [31:0] EX_ENTRY_PC     = 32'hbfc0_0380;

  localparam logic [4:0] CR_BADVADDR = 5'd8;
  localparam logic [4:0] CR_COUNT    = 5'd9;
  localparam logic [4:0] CR_ENTRYHI  = 5'd10;
  localparam logic [4:0] CR_COMPARE  = 5'd11;
  localparam logic [4:0] CR_STATUS   = 5'd12;
  localparam logic [4:0] CR_CAUSE    = 5'd13;
  localparam logic [4:0] CR_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  typedef struct packed {
    logic        tlbwi;
    logic        tlbr;
    logic [31:0] badvaddr;
    logic        eret;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  c0_addr;
    logic        bd;
    logic        ex;
    logic [4:0]  excode;
    logic [3:0]  rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_bus_t;

  // Only select 0 of each register number is implemented.
  function automatic logic is_cr(input logic [7:0] addr, input logic [4:0] rd);
    return addr == {rd, 3'b000};
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 exception/timer registers: Status, Cause, EPC, BadVAddr, Count, Compare,
// plus the half-rate timer and interrupt-pending evaluation.
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int_in,
  input  logic        ex_commit,
  input  logic        eret_commit,
  input  logic        mtc0_we,
  input  logic [7:0]  c0_addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  excode,
  input  logic [31:0] badvaddr,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        int_pending
);

  logic [31:0] status;
  logic [31:0] badvaddr_r;
  logic [31:0] count;
  logic [31:0] compare;
  logic        cause_bd;
  logic        cause_ti;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic        count_tick;
  logic [31:0] cause;
  logic [31:0] count_next;
  logic [31:0] compare_next;
  logic        ti_next;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;

  assign wr_status  = mtc0_we & is_cr(c0_addr, CR_STATUS);
  assign wr_cause   = mtc0_we & is_cr(c0_addr, CR_CAUSE);
  assign wr_epc     = mtc0_we & is_cr(c0_addr, CR_EPC);
  assign wr_count   = mtc0_we & is_cr(c0_addr, CR_COUNT);
  assign wr_compare = mtc0_we & is_cr(c0_addr, CR_COMPARE);

  assign cause = {cause_bd, cause_ti, 14'b0, cause_ip, 1'b0, cause_exc, 2'b00};

  // The timer match looks at post-update Count/Compare, so a match set
  // outranks the clear from a Compare write landing on the same edge.
  always_comb begin
    count_next = count;
    if (wr_count)
      count_next = wdata;
    else if (count_tick)
      count_next = count + 32'd1;
    compare_next = wr_compare ? wdata : compare;
    ti_next = (cause_ti & ~wr_compare) |
              ((count_next == compare_next) && (compare_next != 32'd0));
  end

  always_comb begin
    rdata = 32'd0;
    if (c0_addr[2:0] == 3'd0) begin
      case (c0_addr[7:3])
        CR_BADVADDR: rdata = badvaddr_r;
        CR_COUNT:    rdata = count;
        CR_COMPARE:  rdata = compare;
        CR_STATUS:   rdata = status;
        CR_CAUSE:    rdata = cause;
        CR_EPC:      rdata = epc;
        default:     rdata = 32'd0;
      endcase
    end
  end

  assign int_pending = status[0] & ~status[1] & (|(status[15:8] & cause_ip));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status     <= STATUS_RESET;
      epc        <= 32'd0;
      badvaddr_r <= 32'd0;
      cause_bd   <= 1'b0;
      cause_exc  <= 5'd0;
    end else if (ex_commit) begin
      // A nested exception keeps the original return point.
      if (!status[1]) begin
        epc      <= bd ? pc - 32'd4 : pc;
        cause_bd <= bd;
      end
      cause_exc <= excode;
      status[1] <= 1'b1;
      if ((excode == EXC_ADEL) || (excode == EXC_ADES))
        badvaddr_r <= badvaddr;
    end else if (eret_commit) begin
      status[1] <= 1'b0;
    end else begin
      if (wr_status)
        status <= (status & ~STATUS_WMASK) | (wdata & STATUS_WMASK);
      if (wr_epc)
        epc <= wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_tick <= 1'b0;
      count      <= 32'd0;
      compare    <= 32'd0;
      cause_ti   <= 1'b0;
      cause_ip   <= 8'd0;
    end else begin
      count_tick    <= ~count_tick;
      count         <= count_next;
      compare       <= compare_next;
      cause_ti      <= ti_next;
      cause_ip[7:2] <= {ext_int_in[5] | ti_next, ext_int_in[4:0]};
      if (wr_cause)
        cause_ip[1:0] <= wdata[9:8];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: last pipeline register, register-file commit, forwarding,
// trace outputs and the exception/ERET flush around the CP0 block.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY = EX_ENTRY_PC,
  parameter int          BUS_WD   = MS_TO_WS_BUS_WD
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ms_to_ws_valid,
  input  logic [BUS_WD-1:0] ms_to_ws_bus,
  output logic              ws_allowin,
  input  logic [5:0]        ext_int_in,
  output logic [3:0]        rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [40:0]       ws_fwd_bus,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic              ws_int,
  output logic              ws_tlbwi,
  output logic              ws_tlbr,
  output logic              c0_entryhi_we,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata
);

  ms_bus_t     ws;
  logic        ws_valid;
  logic        ws_ex;
  logic        ws_eret;
  logic        commit_ok;
  logic        mtc0_we;
  logic [31:0] c0_rdata;
  logic [31:0] epc;

  assign ws_allowin = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid <= 1'b0;
      ws       <= '0;
    end else begin
      ws_valid <= ms_to_ws_valid && ws_allowin;
      if (ms_to_ws_valid && ws_allowin)
        ws <= ms_bus_t'(ms_to_ws_bus);
    end
  end

  // An excepting instruction commits nothing except the exception itself.
  assign ws_ex     = ws_valid & ws.ex;
  assign ws_eret   = ws_valid & ws.eret & ~ws.ex;
  assign commit_ok = ws_valid & ~ws.ex;
  assign mtc0_we   = commit_ok & ws.mtc0;

  assign rf_we      = {4{commit_ok}} & ws.rf_we;
  assign rf_waddr   = ws.dest;
  assign rf_wdata   = ws.mfc0 ? c0_rdata : ws.result;
  assign ws_fwd_bus = {rf_we, rf_waddr, rf_wdata};

  assign flush    = ws_ex | ws_eret;
  assign flush_pc = ws_ex ? EX_ENTRY : epc;

  assign ws_tlbwi      = commit_ok & ws.tlbwi;
  assign ws_tlbr       = commit_ok & ws.tlbr;
  assign c0_entryhi_we = mtc0_we & (ws.c0_addr[7:3] == CR_ENTRYHI);

  assign debug_wb_pc       = ws.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  cp0_regs u_cp0 (
    .clk         (clk),
    .resetn      (resetn),
    .ext_int_in  (ext_int_in),
    .ex_commit   (ws_ex),
    .eret_commit (ws_eret),
    .mtc0_we     (mtc0_we),
    .c0_addr     (ws.c0_addr),
    .wdata       (ws.result),
    .pc          (ws.pc),
    .bd          (ws.bd),
    .excode      (ws.excode),
    .badvaddr    (ws.badvaddr),
    .rdata       (c0_rdata),
    .epc         (epc),
    .int_pending (ws_int)
  );

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (write-back) pipeline stage. It consumes the 125-bit memory-stage-to-writeback bus and commits byte-enabled results to the register file.
- Holds the CP0 exception/timer register set: Status, Cause, EPC, BadVAddr, Count, Compare.
- Raises the pipeline-wide flush and its redirect PC on exception or ERET.
- Exports a forwarding bus, debug trace signals, interrupt-pending and TLB-operation strobes.

Parameters:
- EX_ENTRY, 32'hbfc00380, exception handler redirect PC.
- BUS_WD, 125, width of the memory-stage-to-writeback bus.

Ports:
- clk  in  1  clock; all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- ms_to_ws_valid  in  1  upstream has a valid instruction.
- ms_to_ws_bus  in  125  fields, MSB first: tlbwi[124], tlbr[123], badvaddr[122:91], c0_bus[90:80], bd[79], ex[78], excode[77:73], rf_we[72:69], dest[68:64], result[63:32], pc[31:0].
- ws_allowin  out  1  stage can accept.
- ext_int_in  in  6  hardware interrupt lines, level-sensitive.
- rf_we  out  4  register-file byte write enables.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- ws_fwd_bus  out  41  {rf_we[40:37], dest[36:32], wdata[31:0]}.
- flush  out  1  kill all younger stages this cycle.
- flush_pc  out  32  redirect target, valid when flush=1.
- ws_int  out  1  interrupt pending, consumed by decode to tag the next instruction.
- ws_tlbwi  out  1  TLBWI commit strobe.
- ws_tlbr  out  1  TLBR commit strobe.
- c0_entryhi_we  out  1  MTC0 to EntryHi committing.
- debug_wb_pc  out  32  trace: committing PC.
- debug_wb_rf_wen  out  4  trace: byte write enables.
- debug_wb_rf_wnum  out  5  trace: write register.
- debug_wb_rf_wdata  out  32  trace: write data.

Behaviour:
- Reset, asynchronous while resetn=0:
  - ws_valid=0.
  - Status = 32'h0040_0000 (BEV=1, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0.
  - Internal count_tick = 0.
  - All strobes and rf_we = 0. flush=0.
- Handshake:
  - ws_ready_go = 1 (single-cycle stage). ws_allowin = 1.
  - When ms_to_ws_valid=1, latch bus on posedge and set ws_valid=1; otherwise ws_valid<=0.
  - Latency is one cycle from acceptance to commit.
- c0_bus decode: {eret[10], mtc0[9], mfc0[8], c0_addr[7:0]}. c0_addr = {rd[4:0], sel[2:0]}.
  - Recognised rd values: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC; sel=0 only.
  - All other addresses read 0; writes to them are ignored.
- Commit qualifiers:
  - ws_ex = ws_valid & ex.
  - ws_eret = ws_valid & eret & ~ex.
- Register-file write:
  - rf_we = {4{ws_valid & ~ex}} & bus.rf_we.
  - rf_wdata = MFC0 ? c0 read data : result.
  - Forward bus and debug signals mirror these values. debug_wb_pc = pc.
- Exception, when ws_ex:
  - EPC = bd ? pc-4 : pc; suppressed when Status.EXL was already 1.
  - Cause.BD = bd, same suppression. Cause.ExcCode[6:2] = excode.
  - Status.EXL = 1.
  - BadVAddr = badvaddr only when excode is 5'h04 (AdEL) or 5'h05 (AdES).
  - flush=1, flush_pc=EX_ENTRY.
- ERET, when ws_eret: Status.EXL=0, flush=1, flush_pc=EPC.
- flush is combinational and asserted in the same cycle as the committing instruction.
- MTC0 writes (on the same posedge, only if ws_valid & mtc0 & ~ex):
  - Status: IM[15:8], EXL[1], IE[0] writable; BEV is read-only.
  - Cause: IP[9:8] writable only.
  - EPC: full 32 bits.
  - Compare: full 32 bits; also clears Cause.TI.
  - Count: full 32 bits.
  - BadVAddr: read-only.
- Count timer:
  - count_tick toggles every cycle.
  - Count increments when count_tick=1 (half clock rate); wraps 32'hffffffff -> 0.
  - An MTC0 Count write overrides the increment in that cycle.
- Timer interrupt: Cause.TI set when Count==Compare and Compare!=0 after update. TI is sticky until a Compare write.
- Hardware interrupts:
  - Cause.IP[15:10] = ext_int_in, with IP[15] ORed with TI. Sampled every cycle.
- ws_int = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP). Registered view, no combinational path from ext_int_in.
- Strobes:
  - ws_tlbwi / ws_tlbr = ws_valid & bit & ~ex.
  - c0_entryhi_we = ws_valid & mtc0 & (rd==10) & ~ex.
- Simultaneous events (exception takes priority):
  - ex with eret or mtc0: exception wins; no MTC0 write, no EXL clear.
  - MTC0 Cause and timer match in the same cycle: TI set wins over software IP writes; IP[9:8] still written.

Decomposition:
- Shared package (mycpu.h):
  - bus width.
  - CR_* register numbers (CR_BADVADDR=8, CR_COUNT=9, CR_ENTRYHI=10, CR_COMPARE=11, CR_STATUS=12, CR_CAUSE=13, CR_EPC=14).
  - EXC_* codes.
  - EX_ENTRY.
- Sub-module cp0_regs: holds the CP0 registers, the timer and interrupt logic. wb_stage keeps the pipeline register, decode, RF write and flush generation.

Test Plan:
- ADDU result 32'h1234_5678, dest 5, rf_we 4'hf -> next cycle rf_we=4'hf, waddr=5, wdata=32'h12345678, flush=0.
- AdEL (excode 04), pc 32'hbfc0_0100, bd=1, badvaddr 32'h0000_0003 -> flush=1, flush_pc=32'hbfc00380, EPC=32'hbfc000fc, Cause.BD=1, ExcCode=4, BadVAddr=3, EXL=1, rf_we=0.
- MTC0 EPC=32'h8000_0010, then ERET -> flush=1, flush_pc=32'h80000010, EXL=0.
- MTC0 Compare=10, Count=0, Status=32'h0040_8001 -> after about 20 cycles Cause.TI=1, ws_int=1; MTC0 Compare clears TI.
- Exception with EXL already 1 -> EPC and BD unchanged, flush still asserted.
- Assert resetn=0 mid-instruction with ws_valid=1 -> rf_we=0 and Count=0 immediately, without waiting for a clock edge.
